// File: rtl/dsp_result_drain.sv
// Result drain for a pipelined pre-add/mult-add DSP stage: tracks valid slots,
// rounds/saturates P, buffers results in a FIFO and stalls the DSP via ce.
module dsp_result_drain #(
    parameter int SIZEIN = 16,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 8,
    parameter int LAT    = 4,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       dsp_ce,
    input  logic [2*SIZEIN:0]          dsp_p,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_sat,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                sat_count
);

    localparam int PW = 2*SIZEIN + 1;
    localparam int EW = PW + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0]        DEPTH_L = LW'(DEPTH);
    localparam logic signed [EW-1:0] RND     = (SHIFT > 0) ? (EW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Round-half-up shift then clamp; returns {sat, data}. One guard bit keeps the
    // rounding add from overflowing at the positive extreme.
    function automatic logic [OUT_W:0] conv_f(input logic [PW-1:0] p);
        logic signed [EW-1:0] ext;
        logic signed [EW-1:0] r;
        ext = {p[PW-1], p};
        r   = (ext + RND) >>> SHIFT;
        if (r > SAT_MAX) begin
            conv_f = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end else if (r < SAT_MIN) begin
            conv_f = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            conv_f = {1'b0, r[OUT_W-1:0]};
        end
    endfunction

    logic [LAT-1:0]   vpipe_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic [15:0]      sat_count_r;
    logic [OUT_W-1:0] data_mem_r [DEPTH];
    logic             sat_mem_r  [DEPTH];

    logic             pop_s;
    logic             push_s;
    logic             ce_s;
    logic [OUT_W:0]   conv_s;

    // Handshake and stall decode; a pop frees a slot in the same cycle so a full
    // FIFO can still accept the result sitting at the DSP output.
    always_comb begin
        pop_s  = 1'b0;
        ce_s   = 1'b1;
        push_s = 1'b0;
        conv_s = conv_f(dsp_p);
        if (level_r != '0) begin
            pop_s = out_ready;
        end else begin
            pop_s = 1'b0;
        end
        ce_s   = ~vpipe_r[LAT-1] | (level_r < DEPTH_L) | pop_s;
        push_s = ce_s & vpipe_r[LAT-1];
    end

    // Output view of the FIFO head and status.
    always_comb begin
        dsp_ce    = ce_s;
        in_ready  = ce_s;
        out_valid = (level_r != '0);
        out_data  = data_mem_r[rd_ptr_r];
        out_sat   = sat_mem_r[rd_ptr_r];
        level     = level_r;
        sat_count = sat_count_r;
    end

    // Valid-slot shadow of the DSP pipeline; frozen together with the DSP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_r <= '0;
        end else if (ce_s) begin
            vpipe_r <= (vpipe_r << 1) | LAT'(in_valid);
        end else begin
            vpipe_r <= vpipe_r;
        end
    end

    // FIFO storage; cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i] <= '0;
                sat_mem_r[i]  <= 1'b0;
            end
        end else if (push_s) begin
            data_mem_r[wr_ptr_r] <= conv_s[OUT_W-1:0];
            sat_mem_r[wr_ptr_r]  <= conv_s[OUT_W];
        end else begin
            data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
            sat_mem_r[wr_ptr_r]  <= sat_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Saturation event counter, sticky at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_r <= '0;
        end else if (push_s && conv_s[OUT_W] && (sat_count_r != 16'hFFFF)) begin
            sat_count_r <= sat_count_r + 16'd1;
        end else begin
            sat_count_r <= sat_count_r;
        end
    end

endmodule
